// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU run controller: sequencer state encoding and
// the default result latency through the systolic array and result-sync skew.
package tpu_pkg;

    localparam int MATRIX_SIZE        = 8;
    localparam int DEFAULT_RESULT_LAT = 2 * MATRIX_SIZE + 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_W = 3'd1,
        LOAD   = 3'd2,
        LATCH  = 3'd3,
        STREAM = 3'd4,
        DRAIN  = 3'd5,
        DONE   = 3'd6
    } state_t;

endpackage

// File: rtl/valid_delay_line.sv
// DEPTH-deep 1-bit shift register that follows each streamed address to the
// point where its aligned result row leaves the result-sync stage.
module valid_delay_line #(
    parameter int DEPTH = 18
) (
    input  logic clk,
    input  logic rstn,
    input  logic valid_i,
    output logic valid_o,
    output logic any_valid_o
);

    logic [DEPTH-1:0] shift_q;
    logic [DEPTH-1:0] shift_d;

    generate
        if (DEPTH == 1) begin : g_single
            assign shift_d = valid_i;
        end else begin : g_multi
            assign shift_d = {shift_q[DEPTH-2:0], valid_i};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstn) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign valid_o = shift_q[DEPTH-1];

    // Looks at the post-shift contents so the drain can finish exactly on the
    // cycle after the last result row has been presented.
    assign any_valid_o = |shift_d;

endmodule

// File: rtl/tpu_sequencer.sv
// Run controller: waits for a weight tile, reloads the array, streams a
// contiguous UB address range, then waits for the results to drain out.
module tpu_sequencer
    import tpu_pkg::*;
#(
    parameter int ADDRESSSIZE = 10,
    parameter int RESULT_LAT  = DEFAULT_RESULT_LAT
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [ADDRESSSIZE-1:0] base_addr,
    input  logic [ADDRESSSIZE:0]   num_rows,
    input  logic                   fifo_empty,
    output logic                   busy,
    output logic                   fifo_read_enable,
    output logic                   we_rl,
    output logic [ADDRESSSIZE-1:0] sram_address,
    output logic                   valid_address,
    output logic                   addr_ctrl_en,
    output logic                   result_valid,
    output logic                   end_
);

    state_t                 state_q;
    logic [ADDRESSSIZE-1:0] base_q;
    logic [ADDRESSSIZE:0]   num_q;
    logic [ADDRESSSIZE:0]   row_q;
    logic [ADDRESSSIZE-1:0] addr_q;
    logic                   busy_q;
    logic                   pop_q;
    logic                   reload_q;
    logic                   valid_q;
    logic                   end_q;
    logic                   drain_pending;

    valid_delay_line #(
        .DEPTH(RESULT_LAT)
    ) u_valid_delay (
        .clk        (clk),
        .rstn       (rstn),
        .valid_i    (valid_q),
        .valid_o    (result_valid),
        .any_valid_o(drain_pending)
    );

    // Every output is a register written on the transition into the state
    // that owns it, so nothing combinational reaches the pins from inputs.
    // row_q always holds the index of the next row to issue.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            base_q   <= '0;
            num_q    <= '0;
            row_q    <= '0;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            pop_q    <= 1'b0;
            reload_q <= 1'b0;
            valid_q  <= 1'b0;
            end_q    <= 1'b0;
        end else begin
            pop_q    <= 1'b0;
            reload_q <= 1'b0;
            end_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        num_q   <= num_rows;
                        busy_q  <= 1'b1;
                        state_q <= WAIT_W;
                    end
                end
                WAIT_W: begin
                    if (!fifo_empty) begin
                        pop_q   <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    reload_q <= 1'b1;
                    state_q  <= LATCH;
                end
                LATCH: begin
                    if (num_q == '0) begin
                        end_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        addr_q  <= base_q;
                        row_q   <= {{ADDRESSSIZE{1'b0}}, 1'b1};
                        valid_q <= 1'b1;
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (row_q == num_q) begin
                        valid_q <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        // Carry out of the adder is dropped so the range wraps to row 0.
                        addr_q <= base_q + row_q[ADDRESSSIZE-1:0];
                        row_q  <= row_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!drain_pending) begin
                        end_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy             = busy_q;
    assign fifo_read_enable = pop_q;
    assign we_rl            = reload_q;
    assign sram_address     = addr_q;
    assign valid_address    = valid_q;
    assign addr_ctrl_en     = valid_q;
    assign end_             = end_q;

endmodule

// File: tb/tb_tpu_sequencer.sv
// Self-checking bench for tpu_sequencer: a timeline model predicts every
// output each cycle from the start/pop cycles, with directed and random runs.
module tb_tpu_sequencer;

    localparam int AW   = 10;
    localparam int L    = 18;
    localparam int HIST = 8192;

    typedef logic [AW-1:0] addr_t;
    typedef logic [AW:0]   rows_t;

    logic  clk = 1'b0;
    logic  rstn;
    logic  start;
    addr_t base_addr;
    rows_t num_rows;
    logic  fifo_empty;
    logic  busy;
    logic  fifo_read_enable;
    logic  we_rl;
    addr_t sram_address;
    logic  valid_address;
    logic  addr_ctrl_en;
    logic  result_valid;
    logic  end_;

    tpu_sequencer #(
        .ADDRESSSIZE(AW),
        .RESULT_LAT (L)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .start           (start),
        .base_addr       (base_addr),
        .num_rows        (num_rows),
        .fifo_empty      (fifo_empty),
        .busy            (busy),
        .fifo_read_enable(fifo_read_enable),
        .we_rl           (we_rl),
        .sram_address    (sram_address),
        .valid_address   (valid_address),
        .addr_ctrl_en    (addr_ctrl_en),
        .result_valid    (result_valid),
        .end_            (end_)
    );

    always #5 clk = ~clk;

    int cyc  = 0;
    int nVec = 0;
    int nMis = 0;

    // Run timeline: accepted-start cycle, pop cycle (-1 until the FIFO delivers),
    // captured base and row count; everything else is arithmetic on these.
    bit mRun      = 1'b0;
    int mStart    = 0;
    int mPop      = -1;
    int mBase     = 0;
    int mN        = 0;
    int mLastAddr = 0;

    bit eBusy, eFre, eWe, eVa, eRv, eEnd;
    int eAddr;

    bit hBusy [HIST];
    bit hFre  [HIST];
    bit hWe   [HIST];
    bit hVa   [HIST];
    bit hRv   [HIST];
    bit hEnd  [HIST];
    int hAddr [HIST];

    function automatic int runEnd();
        return (mN == 0) ? mPop + 2 : mPop + 2 + mN + L;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        nVec++;
        if (act != exp) begin
            nMis++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Advance the model to cycle k using the inputs that were sampled at this edge.
    always @(posedge clk) begin
        int  k;
        bit  idlePrev;
        cyc = cyc + 1;
        k   = cyc;
        if (!rstn) begin
            mRun      = 1'b0;
            mPop      = -1;
            mLastAddr = 0;
        end else begin
            idlePrev = !mRun || (mPop >= 0 && (k - 1) > runEnd());
            if (idlePrev) begin
                mRun = 1'b0;
                if (start) begin
                    mRun   = 1'b1;
                    mStart = k - 1;
                    mPop   = -1;
                    mBase  = int'(base_addr);
                    mN     = int'(num_rows);
                end
            end else if (mPop < 0 && (k - 1) >= mStart + 1 && !fifo_empty) begin
                mPop = k;
            end
        end
        eBusy = mRun && (k >= mStart + 1) && (mPop < 0 || k <= runEnd());
        eFre  = mRun && (mPop >= 0) && (k == mPop);
        eWe   = mRun && (mPop >= 0) && (k == mPop + 1);
        eVa   = mRun && (mPop >= 0) && (mN > 0) && (k >= mPop + 2) && (k <= mPop + 1 + mN);
        eRv   = mRun && (mPop >= 0) && (mN > 0) && (k >= mPop + 2 + L) && (k <= mPop + 1 + mN + L);
        eEnd  = mRun && (mPop >= 0) && (k == runEnd());
        if (eVa) begin
            mLastAddr = (mBase + (k - mPop - 2)) % (1 << AW);
        end
        eAddr = mLastAddr;
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            checkOutput("busy", int'(busy), int'(eBusy));
            checkOutput("fifo_read_enable", int'(fifo_read_enable), int'(eFre));
            checkOutput("we_rl", int'(we_rl), int'(eWe));
            checkOutput("sram_address", int'(sram_address), eAddr);
            checkOutput("valid_address", int'(valid_address), int'(eVa));
            checkOutput("addr_ctrl_en", int'(addr_ctrl_en), int'(eVa));
            checkOutput("result_valid", int'(result_valid), int'(eRv));
            checkOutput("end_", int'(end_), int'(eEnd));
            if (cyc < HIST) begin
                hBusy[cyc] = busy;
                hFre[cyc]  = fifo_read_enable;
                hWe[cyc]   = we_rl;
                hVa[cyc]   = valid_address;
                hRv[cyc]   = result_valid;
                hEnd[cyc]  = end_;
                hAddr[cyc] = int'(sram_address);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; returns the cycle in which start was high.
    task automatic applyStimulus(input int b, input int n, output int startCycle);
        start      = 1'b1;
        base_addr  = addr_t'(b);
        num_rows   = rows_t'(n);
        startCycle = cyc;
        tick();
        start      = 1'b0;
        base_addr  = addr_t'($urandom);
        num_rows   = rows_t'($urandom);
    endtask

    task automatic waitIdle(input int limit, input bit randomize);
        int c = 0;
        while (busy && c < limit) begin
            if (randomize) begin
                fifo_empty = ($urandom_range(0, 2) == 0);
                start      = ($urandom_range(0, 9) == 0);
                base_addr  = addr_t'($urandom);
                num_rows   = rows_t'($urandom_range(0, 12));
            end
            tick();
            c++;
        end
        start      = 1'b0;
        fifo_empty = 1'b0;
        nVec++;
        if (busy) begin
            nMis++;
            $display("[TB] FAIL wait_idle timeout: busy=%0d after %0d cycles, expected 0", busy, c);
        end
    endtask

    function automatic int countEnds(input int from, input int to);
        int n = 0;
        for (int i = from; i <= to; i++) begin
            if (i >= 0 && i < HIST && hEnd[i]) n++;
        end
        return n;
    endfunction

    initial begin
        int s;
        int d;
        int r;
        int c;
        int n;
        rstn       = 1'b0;
        start      = 1'b0;
        fifo_empty = 1'b0;
        base_addr  = '0;
        num_rows   = '0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_addr", int'(sram_address), 0);
        checkOutput("reset_end", int'(end_), 0);

        $display("[TB] basic run");
        applyStimulus('h010, 4, s);
        waitIdle(200, 1'b0);
        repeat (2) tick();
        checkOutput("basic_no_early_pop", int'(hFre[s+1]), 0);
        checkOutput("basic_pop", int'(hFre[s+2]), 1);
        checkOutput("basic_we_rl", int'(hWe[s+3]), 1);
        checkOutput("basic_addr_first", hAddr[s+4], 'h010);
        checkOutput("basic_addr_last", hAddr[s+7], 'h013);
        checkOutput("basic_va_after", int'(hVa[s+8]), 0);
        checkOutput("basic_rv_before", int'(hRv[s+21]), 0);
        checkOutput("basic_rv_first", int'(hRv[s+22]), 1);
        checkOutput("basic_rv_last", int'(hRv[s+25]), 1);
        checkOutput("basic_rv_after", int'(hRv[s+26]), 0);
        checkOutput("basic_end", int'(hEnd[s+26]), 1);
        checkOutput("basic_busy_done", int'(hBusy[s+26]), 1);
        checkOutput("basic_busy_off", int'(hBusy[s+27]), 0);

        $display("[TB] fifo stall");
        fifo_empty = 1'b1;
        applyStimulus('h020, 3, s);
        repeat (5) tick();
        fifo_empty = 1'b0;
        waitIdle(200, 1'b0);
        repeat (2) tick();
        checkOutput("stall_no_pop", int'(hFre[s+6]), 0);
        checkOutput("stall_pop", int'(hFre[s+7]), 1);
        checkOutput("stall_we_rl", int'(hWe[s+8]), 1);
        checkOutput("stall_end", int'(hEnd[s+30]), 1);

        $display("[TB] wrap and zero rows");
        applyStimulus('h3FE, 4, s);
        waitIdle(200, 1'b0);
        repeat (2) tick();
        checkOutput("wrap_addr0", hAddr[s+4], 'h3FE);
        checkOutput("wrap_addr1", hAddr[s+5], 'h3FF);
        checkOutput("wrap_addr2", hAddr[s+6], 'h000);
        checkOutput("wrap_addr3", hAddr[s+7], 'h001);
        applyStimulus('h155, 0, s);
        waitIdle(200, 1'b0);
        repeat (2) tick();
        checkOutput("zero_we_rl", int'(hWe[s+3]), 1);
        checkOutput("zero_end", int'(hEnd[s+4]), 1);
        checkOutput("zero_no_va", int'(hVa[s+4]), 0);
        checkOutput("zero_busy_off", int'(hBusy[s+5]), 0);

        $display("[TB] start collisions");
        applyStimulus('h100, 8, s);
        repeat (5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (!end_ && c < 100) begin
            tick();
            c++;
        end
        nVec++;
        if (!end_) begin
            nMis++;
            $display("[TB] FAIL collide_end_wait: end_=0 after %0d cycles, expected 1", c);
        end
        d          = cyc;
        start      = 1'b1;
        base_addr  = addr_t'('h200);
        num_rows   = rows_t'(2);
        tick();
        tick();
        start = 1'b0;
        waitIdle(200, 1'b0);
        repeat (2) tick();
        checkOutput("collide_single_end", countEnds(s, d), 1);
        checkOutput("collide_idle_gap", int'(hBusy[d+1]), 0);
        checkOutput("collide_restart", int'(hBusy[d+2]), 1);

        $display("[TB] reset mid-run");
        applyStimulus('h050, 20, s);
        repeat (7) tick();
        rstn = 1'b0;
        r    = cyc;
        tick();
        rstn = 1'b1;
        tick();
        checkOutput("midreset_busy", int'(hBusy[r+1]), 0);
        checkOutput("midreset_addr", hAddr[r+1], 0);
        checkOutput("midreset_va", int'(hVa[r+1]), 0);
        applyStimulus('h060, 3, s);
        waitIdle(200, 1'b0);
        repeat (2) tick();
        checkOutput("midreset_no_end", countEnds(r - 8, r + 10), 0);
        checkOutput("midreset_rerun_end", countEnds(r + 11, cyc), 1);

        $display("[TB] random runs");
        for (int it = 0; it < 30; it++) begin
            repeat ($urandom_range(0, 3)) tick();
            n          = (it == 10) ? (1 << AW) : $urandom_range(0, 30);
            fifo_empty = ($urandom_range(0, 1) == 0);
            applyStimulus($urandom_range(0, (1 << AW) - 1), n, s);
            waitIdle(3000, 1'b1);
            while (busy) begin
                waitIdle(3000, 1'b0);
            end
        end
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/tpu_sequencer.md
# tpu_sequencer

Top-level run controller for the TPU datapath. One `start` pulse triggers the sequence:
- wait for a weight tile in the Weight FIFO, pop it, and pulse the systolic array's weight-reload;
- stream a contiguous range of Unified Buffer addresses into the data-setup path;
- track results through the array and result-sync skew, then signal completion.

It sits beside the SRAM UB, Weight FIFO and systolic array, and drives their control pins in place of external stimulus.

## Interface
- `ADDRESSSIZE`, 10, UB address width
- `RESULT_LAT`, 18, cycles from an address on `sram_address` to its aligned result row at the `result_sync` output; must be ≥1
- `clk`  in  1  clock
- `rstn`  in  1  synchronous, active-low reset
- `start`  in  1  run request, sampled only in IDLE
- `base_addr`  in  ADDRESSSIZE  first UB row, captured on an accepted `start`
- `num_rows`  in  ADDRESSSIZE+1  rows to stream (0..2^ADDRESSSIZE), captured on an accepted `start`
- `fifo_empty`  in  1  Weight FIFO empty flag
- `busy`  out  1  high from the cycle after an accepted `start` through DONE
- `fifo_read_enable`  out  1  Weight FIFO pop, single-cycle
- `we_rl`  out  1  weight reload to the array, single-cycle
- `sram_address`  out  ADDRESSSIZE  UB read address
- `valid_address`  out  1  `sram_address` is a live activation row
- `addr_ctrl_en`  out  1  equals `valid_address`; enables the address controller
- `result_valid`  out  1  `result_sync` carries a valid row this cycle
- `end_`  out  1  run complete, single-cycle pulse

## Operation
- States: IDLE, WAIT_W, LOAD, LATCH, STREAM, DRAIN, DONE.
- **IDLE**
  - `start`=1: capture `base_addr` and `num_rows`, go to WAIT_W.
  - Otherwise stay.
- **WAIT_W**
  - `fifo_empty`=0: go to LOAD.
  - Otherwise stay indefinitely; no timeout.
- **LOAD:** `fifo_read_enable`=1, go to LATCH.
- **LATCH**
  - `we_rl`=1.
  - `num_rows`=0: go to DONE; there is no STREAM or DRAIN.
  - Otherwise go to STREAM.
- **STREAM**
  - Row counter i runs 0..num_rows−1.
  - `sram_address` = (base+i) mod 2^ADDRESSSIZE; an address past the top wraps to 0.
  - `valid_address` = `addr_ctrl_en` = 1.
  - Go to DRAIN after i = num_rows−1.
- **DRAIN:** stay until the result-valid delay line is empty, then go to DONE.
- **DONE:** `end_`=1, go to IDLE.
- `result_valid` is `valid_address` delayed exactly RESULT_LAT cycles by a shift register.
- `start` outside IDLE is ignored. It is not queued.
- `fifo_empty` asserting after LOAD has no effect on the run.
- All outputs are Moore, decoded from state and registers; no input-to-output combinational path.
- Outside STREAM, `sram_address` holds its last value (0 after reset).
- Row counter width: ADDRESSSIZE+1. Address adder: ADDRESSSIZE bits, carry discarded.

## Timing
- Reset (`rstn`=0 at a clock edge):
  - state→IDLE;
  - delay line and counters cleared;
  - all outputs 0, including `sram_address`.
- Reset mid-run aborts the run with no `end_` pulse. The FIFO pop already issued is not undone.
- With `start` at cycle 0 and `fifo_empty`=0 at cycle 1, for N ≥ 1:
  - cycle 1 WAIT_W (`busy`=1);
  - cycle 2 `fifo_read_enable`;
  - cycle 3 `we_rl`;
  - cycles 4..N+3 addresses;
  - cycles 4+L..N+3+L `result_valid`;
  - cycle N+4+L `end_`;
  - cycle N+5+L `busy`=0.
- Each cycle `fifo_empty` stays high delays everything from LOAD onward by one cycle.
- N=0 timing: `we_rl` at cycle 3, `end_` at cycle 4.
- `start` may be asserted in the cycle `end_` is high; the next run is accepted from IDLE on the following cycle.

## Structure
- Shared package `tpu_pkg` holds:
  - the state encoding (3-bit, IDLE=0);
  - a default RESULT_LAT localparam, derived as 2·MATRIX_SIZE+2.
- One sub-module, `valid_delay_line`: a RESULT_LAT-deep 1-bit shift register with synchronous clear, plus an `any_valid` OR-reduce output used for the DRAIN exit.
- Everything else (FSM, row counter, address adder) lives in `tpu_sequencer`.

## Test plan
- **Basic run.** Reset, `fifo_empty`=0, `start`, base=0x010, N=4, L=18:
  - pop at cycle 2, `we_rl` at cycle 3;
  - addresses 0x010–0x013 at cycles 4–7;
  - `result_valid` at cycles 22–25;
  - `end_` at cycle 26.
- **FIFO stall.** Hold `fifo_empty`=1 for 5 cycles after `start`: no pop or `we_rl` while empty; pop occurs the cycle after `fifo_empty` falls; all later events shift by 5.
- **Wrap and zero rows.**
  - base=0x3FE, N=4: addresses 0x3FE, 0x3FF, 0x000, 0x001.
  - N=0: `we_rl` at cycle 3, `end_` at cycle 4, `valid_address` never high.
- **Start collisions.** Second `start` pulses during STREAM and DRAIN are ignored (single `end_`). `start` in the DONE cycle launches a second run whose WAIT_W begins 2 cycles later.
- **Reset mid-run.** `rstn`=0 during STREAM: the next cycle has all outputs 0 and state IDLE, `end_` never pulses, and a fresh `start` completes normally.
